// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, memory size.
package lsu_pkg;

  localparam int MEM_BYTES_DEF = 512;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: load extract/extend and store read-modify-write merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] sdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{off, 3'b000} +: 8];
    half_v = word[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'h0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'h0, half_v};
      default: load_data = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B:    store_word[{off, 3'b000} +: 8] = sdata[7:0];
      F3_H:    store_word[{off[1], 4'b0000} +: 16] = sdata[15:0];
      default: store_word = sdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit driving a word-wide data memory; sub-word stores use read-modify-write.
// LSU_MISALIGN_TRAP_EN: misaligned accesses fault; otherwise low address bits are forced aligned.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, merged_q;
  logic [1:0]        off;
  logic              mis_fault, fault;
  logic [31:0]       load_data, store_word;

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    off = addr_q[1:0];
    case (f3_q[1:0])
      2'b01:   mis_fault = addr_q[0];
      2'b10:   mis_fault = |addr_q[1:0];
      default: mis_fault = 1'b0;
    endcase
`else
    // Misaligned requests are silently rounded down to natural alignment.
    mis_fault = 1'b0;
    case (f3_q[1:0])
      2'b01:   off = {addr_q[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = addr_q[1:0];
    endcase
`endif
    fault = mis_fault || (addr_q >= ADDR_W'(MEM_BYTES)) || f3_illegal(we_q, f3_q);
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .off        (off),
    .word       (mem_rdata),
    .sdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_raddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_waddr  = {addr_q[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    case (state)
      IDLE: if (req_valid) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = RESP;
        if (!fault) begin
          if (!we_q) begin
            mem_re = 1'b1;
          end else if (f3_q == F3_W) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
          end else begin
            mem_re    = 1'b1;
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = merged_q;
        state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      merged_q   <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS) begin
        resp_err   <= fault;
        resp_rdata <= (fault || we_q) ? 32'h0 : load_data;
        merged_q   <= store_word;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a behavioural word memory.
module tb_lsu;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;

  logic [31:0] mem [0:127];
  int checks = 0;
  int passed = 0;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_raddr[8:2]];
  always @(posedge clk) if (mem_we) mem[mem_waddr[8:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request from IDLE (called at posedge+1) and follow it to its response.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat,
                     output int rec, output int wec, output logic [31:0] wword);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; rec = 0; wec = 0; wword = 32'h0;
    while (!resp_valid && lat < 10) begin
      if (mem_re) rec++;
      if (mem_we) begin wec++; wword = mem_wdata; end
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, ww;
    logic        er;
    int          lat, rec, wec;
    logic [5:0]  rdy_bits, rsp_bits;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_re_we", {30'h0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_raddr", mem_raddr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Word load
    run(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, rec, wec, ww);
    chk("lw_rdata", rd, 32'h8899AABB);
    chk("lw_err", 32'(er), 32'd0);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_re_cnt", 32'(rec), 32'd1);
    chk("lw_we_cnt", 32'(wec), 32'd0);

    // Sub-word loads
    run(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat, rec, wec, ww);
    chk("lb_0x13", rd, 32'hFFFFFF88);
    run(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat, rec, wec, ww);
    chk("lbu_0x13", rd, 32'h00000088);
    run(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat, rec, wec, ww);
    chk("lh_0x12", rd, 32'hFFFF8899);
    run(1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat, rec, wec, ww);
    chk("lhu_0x10", rd, 32'h0000AABB);
    run(1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat, rec, wec, ww);
    chk("lb_0x10", rd, 32'hFFFFFFBB);

    // Byte store via read-modify-write
    run(1'b1, 3'b000, 32'h11, 32'hDEADBECC, rd, er, lat, rec, wec, ww);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_we_cnt", 32'(wec), 32'd1);
    chk("sb_wdata", ww, 32'h8899CCBB);
    chk("sb_mem", mem[4], 32'h8899CCBB);
    chk("sb_rdata_err", {resp_rdata[30:0], er} , 32'h0);

    // Halfword and word stores
    mem[4] = 32'h8899AABB;
    run(1'b1, 3'b001, 32'h12, 32'h00001234, rd, er, lat, rec, wec, ww);
    chk("sh_mem", mem[4], 32'h1234AABB);
    chk("sh_we_cnt", 32'(wec), 32'd1);
    run(1'b1, 3'b010, 32'h14, 32'hCAFEF00D, rd, er, lat, rec, wec, ww);
    chk("sw_mem", mem[5], 32'hCAFEF00D);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_we_cnt", 32'(wec), 32'd1);
    chk("sw_re_cnt", 32'(rec), 32'd0);
    chk("sw_rdata", rd, 32'h0);

    // Faults and alignment handling
    mem[4] = 32'h8899AABB;
    run(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat, rec, wec, ww);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'h0);
    chk("lw_mis_re", 32'(rec), 32'd0);
`else
    chk("lw_mis_err", 32'(er), 32'd0);
    chk("lw_mis_rdata", rd, 32'h8899AABB);
    chk("lw_mis_re", 32'(rec), 32'd1);
`endif
    run(1'b0, 3'b010, 32'h200, 32'h0, rd, er, lat, rec, wec, ww);
    chk("lw_range_err", 32'(er), 32'd1);
    chk("lw_range_re", 32'(rec), 32'd0);
    chk("lw_range_lat", 32'(lat), 32'd2);
    run(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat, rec, wec, ww);
    chk("ld_f3_err", 32'(er), 32'd1);
    chk("ld_f3_rdata", rd, 32'h0);
    run(1'b1, 3'b100, 32'h10, 32'h11223344, rd, er, lat, rec, wec, ww);
    chk("st_f3_err", 32'(er), 32'd1);
    chk("st_f3_we", 32'(wec), 32'd0);
    chk("st_f3_mem", mem[4], 32'h8899AABB);

    // Reset during the WRITE cycle of a byte store
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_we_after", 32'(mem_we), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("mid_mem", mem[4], 32'h8899AABB);
    rst = 1'b0;
    rsp_bits = 6'h0;
    for (int k = 0; k < 4; k++) begin
      rsp_bits[k] = resp_valid;
      @(posedge clk); #1;
    end
    chk("mid_no_resp", 32'(rsp_bits), 32'd0);

    // Back-to-back requests with req_valid held high
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    rdy_bits = 6'h0; rsp_bits = 6'h0;
    for (int k = 0; k < 6; k++) begin
      rdy_bits[k] = req_ready;
      rsp_bits[k] = resp_valid;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b_ready", 32'(rdy_bits), 32'h09);
    chk("b2b_resp", 32'(rsp_bits), 32'h24);
    chk("b2b_rdata", resp_rdata, 32'h8899AABB);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
